// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-tick divider, h/v counters, registered sync/blank.
// Define VGA_SYNC_ALIGN_EN to delay hsync/vsync/blank_n by one pixel.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active_pixels,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic       vga_clk,
   output logic       pix_tick,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = $clog2(CLK_DIV);

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div_cnt;
   logic          tick;
   logic [9:0]    h_cnt;
   logic [9:0]    v_cnt;
   logic [9:0]    h_nxt;
   logic [9:0]    v_nxt;
   logic          act_r;
   logic          hs_r;
   logic          vs_r;
   logic          pt_r;
   logic          fs_r;

   assign tick = (div_cnt == DIV_LAST);

   // >= on the wrap compares keeps the counters inside range even if upset
   always_comb begin
      h_nxt = h_cnt + 10'd1;
      v_nxt = v_cnt;
      if (h_cnt >= H_LAST) begin
         h_nxt = 10'd0;
         if (v_cnt >= V_LAST) v_nxt = 10'd0;
         else                 v_nxt = v_cnt + 10'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         h_cnt   <= 10'd0;
         v_cnt   <= 10'd0;
         act_r   <= 1'b0;
         hs_r    <= 1'b1;
         vs_r    <= 1'b1;
         pt_r    <= 1'b0;
         fs_r    <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DW'(1);
         pt_r    <= tick;
         fs_r    <= tick && (h_nxt == 10'd0) && (v_nxt == 10'd0);
         if (tick) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            act_r <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
            hs_r  <= !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
            vs_r  <= !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
         end
      end
   end

`ifdef VGA_SYNC_ALIGN_EN
   logic hs_d;
   logic vs_d;
   logic bn_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_d <= 1'b1;
         vs_d <= 1'b1;
         bn_d <= 1'b0;
      end else if (tick) begin
         hs_d <= hs_r;
         vs_d <= vs_r;
         bn_d <= act_r;
      end
   end

   assign hsync   = hs_d;
   assign vsync   = vs_d;
   assign blank_n = bn_d;
`else
   assign hsync   = hs_r;
   assign vsync   = vs_r;
   assign blank_n = act_r;
`endif

   assign x             = h_cnt;
   assign y             = v_cnt;
   assign active_pixels = act_r;
   assign pix_tick      = pt_r;
   assign frame_start   = fs_r;
   assign vga_clk       = (div_cnt >= DIV_HALF);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster, checked against a
// pixel-index model derived from elapsed clocks since reset release.
module tb_vga_timing_gen;

   localparam int HA = 8;
   localparam int HF = 2;
   localparam int HS = 3;
   localparam int HB = 2;
   localparam int VA = 6;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 1;
   localparam int D  = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

`ifdef VGA_SYNC_ALIGN_EN
   localparam int LAG = 1;
`else
   localparam int LAG = 0;
`endif

   localparam logic [26:0] RST_VEC =
      {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] x;
   logic [9:0] y;
   logic       active_pixels;
   logic       hsync;
   logic       vsync;
   logic       blank_n;
   logic       vga_clk;
   logic       pix_tick;
   logic       frame_start;

   int errors = 0;
   int checks = 0;
   int n      = 0;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .CLK_DIV(D)
   ) dut (
      .clk(clk),
      .rst(rst),
      .x(x),
      .y(y),
      .active_pixels(active_pixels),
      .hsync(hsync),
      .vsync(vsync),
      .blank_n(blank_n),
      .vga_clk(vga_clk),
      .pix_tick(pix_tick),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   logic [26:0] obs;
   assign obs = {x, y, active_pixels, hsync, vsync, blank_n,
                 vga_clk, pix_tick, frame_start};

   // Expected outputs n clocks after reset release: pixel k = n/D.
   function automatic logic [26:0] model(int nn);
      int k, p, q, xx, yy, qx, qy;
      logic a, hs, vs, bn, vc, pt, fs;
      vc = (nn % D) >= (D / 2);
      if (nn < D)
         return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, vc, 1'b0, 1'b0};
      k  = nn / D;
      p  = k % FT;
      xx = p % HT;
      yy = p / HT;
      a  = (xx < HA) && (yy < VA);
      q  = (k - LAG) % FT;
      qx = q % HT;
      qy = q / HT;
      hs = !(qx >= HA + HF && qx < HA + HF + HS);
      vs = !(qy >= VA + VF && qy < VA + VF + VS);
      bn = (qx < HA) && (qy < VA);
      if (k - LAG < 1) begin
         hs = 1'b1;
         vs = 1'b1;
         bn = 1'b0;
      end
      pt = (nn % D) == 0;
      fs = pt && (p == 0);
      return {10'(xx), 10'(yy), a, hs, vs, bn, vc, pt, fs};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic test_reset();
      int len;
      len = $urandom_range(9, 5);
      rst = 1'b1;
      for (int i = 0; i < len; i++) begin
         step();
         checks++;
         if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, RST_VEC);
         end
      end
      rst = 1'b0;
      n = 0;
   endtask

   task automatic test_free_run(input int len);
      logic [26:0] e;
      for (int i = 0; i < len; i++) begin
         step();
         e = model(n);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL free_run n=%0d got=%h exp=%h", n, obs, e);
         end
      end
   endtask

   task automatic test_first_tick();
      for (int i = 0; i < D; i++) step();
      checks++;
      if (!(pix_tick === 1'b1 && x === 10'd1 && y === 10'd0
            && active_pixels === 1'b1 && frame_start === 1'b0)) begin
         errors++;
         $display("FAIL first_tick got pt=%b x=%0d y=%0d act=%b fs=%b exp pt=1 x=1 y=0 act=1 fs=0",
                  pix_tick, x, y, active_pixels, frame_start);
      end
   endtask

   task automatic test_line();
      int ticks, lows, first_low, rise, bad_act, t;
      bit ok;
      ok = 0;
      for (t = 0; t < FT * D + 10; t++) begin
         step();
         if (pix_tick && x == 10'd0) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL line_sync timeout got=none exp=x0_tick");
         return;
      end
      ticks = 0; lows = 0; first_low = -1; rise = -1; bad_act = 0;
      ok = 0;
      for (t = 0; t < HT * D + 10; t++) begin
         step();
         if (pix_tick) begin
            ticks++;
            if (!hsync) begin
               lows++;
               if (first_low < 0) first_low = int'(x);
            end else if (first_low >= 0 && rise < 0) begin
               rise = int'(x);
            end
            if (active_pixels !== ((int'(x) < HA) && (int'(y) < VA))) bad_act++;
            if (x == 10'd0) begin ok = 1; break; end
         end
      end
      checks++;
      if (!ok || ticks != HT) begin
         errors++;
         $display("FAIL line_ticks got=%0d exp=%0d", ticks, HT);
      end
      checks++;
      if (lows != HS) begin
         errors++;
         $display("FAIL hsync_width got=%0d exp=%0d", lows, HS);
      end
      checks++;
      if (first_low != HA + HF + LAG) begin
         errors++;
         $display("FAIL hsync_first_low got=%0d exp=%0d", first_low, HA + HF + LAG);
      end
      checks++;
      if (rise != HA + HF + HS + LAG) begin
         errors++;
         $display("FAIL hsync_rise got=%0d exp=%0d", rise, HA + HF + HS + LAG);
      end
      checks++;
      if (bad_act != 0) begin
         errors++;
         $display("FAIL line_active got=%0d_bad exp=0", bad_act);
      end
   endtask

   task automatic test_frame();
      int clks, act, vlow, t;
      bit ok;
      ok = 0;
      for (t = 0; t < FT * D + 10; t++) begin
         step();
         if (frame_start) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL frame_sync timeout got=none exp=frame_start");
         return;
      end
      clks = 0; act = 0; vlow = 0; ok = 0;
      for (t = 0; t < FT * D + 10; t++) begin
         step();
         clks++;
         if (!vsync) vlow++;
         if (frame_start) begin ok = 1; break; end
         if (pix_tick && active_pixels) act++;
      end
      if (pix_tick && active_pixels) act++;
      checks++;
      if (!ok || clks != FT * D) begin
         errors++;
         $display("FAIL frame_period got=%0d exp=%0d", clks, FT * D);
      end
      checks++;
      if (act != HA * VA) begin
         errors++;
         $display("FAIL frame_active got=%0d exp=%0d", act, HA * VA);
      end
      checks++;
      if (vlow != VS * HT * D) begin
         errors++;
         $display("FAIL vsync_width got=%0d exp=%0d", vlow, VS * HT * D);
      end
   endtask

   task automatic test_wrap(input int ty);
      int t, ey;
      bit ok;
      ok = 0;
      for (t = 0; t < FT * D + 10; t++) begin
         step();
         if (pix_tick && int'(x) == HT - 1 && int'(y) == ty) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wrap_find y=%0d timeout", ty);
         return;
      end
      for (t = 0; t < D; t++) step();
      ey = (ty == VT - 1) ? 0 : ty + 1;
      checks++;
      if (!(pix_tick === 1'b1 && x === 10'd0 && int'(y) == ey
            && frame_start === (ey == 0))) begin
         errors++;
         $display("FAIL wrap_y%0d got x=%0d y=%0d fs=%b exp x=0 y=%0d fs=%b",
                  ty, x, y, frame_start, ey, ey == 0);
      end
   endtask

   task automatic test_reset_mid();
      int pre, hold;
      pre  = $urandom_range(FT * D - 1, 1);
      hold = $urandom_range(4, 1);
      for (int i = 0; i < pre; i++) step();
      rst = 1'b1;
      step();
      checks++;
      if (obs !== RST_VEC) begin
         errors++;
         $display("FAIL reset_mid got=%h exp=%h", obs, RST_VEC);
      end
      for (int i = 0; i < hold; i++) step();
      rst = 1'b0;
      n = 0;
      test_free_run(2 * HT * D + $urandom_range(D, 0));
   endtask

   initial begin
      test_reset();
      test_first_tick();
      test_free_run(FT * D + $urandom_range(200, 0));
      test_line();
      test_frame();
      test_wrap(VT - 1);
      test_wrap($urandom_range(VT - 2, 0));
      test_reset_mid();
      test_reset_mid();
      test_free_run(FT * D + 20);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
